// File: rtl/eda_frame_sequencer.sv
// Frame loader and center sweeper that sits in front of eda_regional_max.
// It streams one raster-order frame into the core memory, then walks center_addr over every pixel.
module eda_frame_sequencer #(
    parameter int M           = 6,
    parameter int N           = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int I_WIDTH     = (M > 1) ? $clog2(M) : 1,
    parameter int J_WIDTH     = (N > 1) ? $clog2(N) : 1,
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   s_ready,
    input  logic                   abort,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic [ADDR_WIDTH-1:0]  center_addr,
    output logic                   center_valid,
    input  logic                   center_done,
    output logic                   frame_done,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t                   state_q;
    logic [I_WIDTH-1:0]       row_q, row_d;
    logic [J_WIDTH-1:0]       col_q, col_d;
    logic                     s_ready_q;
    logic                     write_en_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [PIXEL_WIDTH-1:0]   pixel_out_q;
    logic [ADDR_WIDTH-1:0]    center_addr_q;
    logic                     center_valid_q;
    logic                     frame_done_q;
    logic                     last_pos;
    logic                     handshake;

    // One row/col counter pair serves both the load and the sweep; it always sits at 0 in IDLE.
    always_comb begin
        last_pos = (row_q == I_WIDTH'(M - 1)) && (col_q == J_WIDTH'(N - 1));
        col_d    = col_q + 1'b1;
        row_d    = row_q;
        if (col_q == J_WIDTH'(N - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
    end

    assign handshake = s_valid && s_ready_q;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q        <= IDLE;
            row_q          <= '0;
            col_q          <= '0;
            s_ready_q      <= 1'b0;
            write_en_q     <= 1'b0;
            wr_addr_q      <= '0;
            pixel_out_q    <= '0;
            center_addr_q  <= '0;
            center_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            write_en_q   <= handshake;
            frame_done_q <= 1'b0;
            if (handshake) begin
                wr_addr_q   <= {row_q, col_q};
                pixel_out_q <= s_pixel;
            end
            case (state_q)
                IDLE, LOAD: begin
                    s_ready_q <= 1'b1;
                    if (handshake) begin
                        // The last pixel's write and the first center appear in the same cycle.
                        if (last_pos) begin
                            state_q        <= SWEEP;
                            row_q          <= '0;
                            col_q          <= '0;
                            center_addr_q  <= '0;
                            center_valid_q <= 1'b1;
                            s_ready_q      <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                            row_q   <= row_d;
                            col_q   <= col_d;
                        end
                    end
                end
                SWEEP: begin
                    if (center_valid_q && center_done) begin
                        if (last_pos) begin
                            state_q        <= IDLE;
                            row_q          <= '0;
                            col_q          <= '0;
                            center_addr_q  <= '0;
                            center_valid_q <= 1'b0;
                            frame_done_q   <= 1'b1;
                            s_ready_q      <= 1'b1;
                        end else begin
                            row_q         <= row_d;
                            col_q         <= col_d;
                            center_addr_q <= {row_d, col_d};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign write_en     = write_en_q;
    assign wr_addr      = wr_addr_q;
    assign pixel_out    = pixel_out_q;
    assign center_addr  = center_addr_q;
    assign center_valid = center_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_eda_frame_sequencer.sv
// Self-checking bench for eda_frame_sequencer: a hand-derived vector table, directed frame
// scenarios and a randomized run, all compared against a pixel/center counting model.
module tb_eda_frame_sequencer;

    localparam int M  = 6;
    localparam int N  = 6;
    localparam int PW = 8;
    localparam int JW = 3;
    localparam int AW = 6;
    localparam int MN = M * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic [PW-1:0] s_pixel;
    logic          s_ready;
    logic          abort;
    logic          write_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] pixel_out;
    logic [AW-1:0] center_addr;
    logic          center_valid;
    logic          center_done;
    logic          frame_done;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts of pixels accepted and centers completed in the current frame.
    int            phase;
    int            loadCount;
    int            centerCount;
    logic          expReady, expWe, expCv, expFd;
    logic [AW-1:0] expWrAddr, expCAddr;
    logic [PW-1:0] expPix;
    int            weSeen;
    int            fdSeen;

    typedef struct {
        logic          rst;
        logic          abt;
        logic          sv;
        logic [PW-1:0] pix;
        logic          cd;
        logic          eReady;
        logic          eWe;
        logic [AW-1:0] eAddr;
        logic [PW-1:0] ePix;
        logic          eBusy;
        logic          eCv;
        logic          eFd;
    } vec_t;

    vec_t vecs[10];

    eda_frame_sequencer #(.M(M), .N(N), .PIXEL_WIDTH(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_pixel      (s_pixel),
        .s_ready      (s_ready),
        .abort        (abort),
        .write_en     (write_en),
        .wr_addr      (wr_addr),
        .pixel_out    (pixel_out),
        .center_addr  (center_addr),
        .center_valid (center_valid),
        .center_done  (center_done),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addrOf(int k);
        int v;
        v = ((k / N) << JW) | (k % N);
        return v[AW-1:0];
    endfunction

    task automatic checkValue(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic modelEdge();
        bit hs;
        hs = s_valid && expReady;
        if (reset || abort) begin
            phase = 0; loadCount = 0; centerCount = 0;
            expReady = 0; expWe = 0; expWrAddr = '0; expPix = '0;
            expCAddr = '0; expCv = 0; expFd = 0;
        end else begin
            expFd = 0;
            expWe = hs;
            if (hs) begin
                expWrAddr = addrOf(loadCount);
                expPix    = s_pixel;
                loadCount++;
                if (loadCount == MN) begin
                    phase = 2; centerCount = 0; expCv = 1; expCAddr = '0; expReady = 0;
                end else begin
                    phase = 1; expReady = 1;
                end
            end else if (phase == 2 && center_done) begin
                centerCount++;
                if (centerCount == MN) begin
                    phase = 0; loadCount = 0; expCv = 0; expFd = 1; expReady = 1; expCAddr = '0;
                end else begin
                    expCAddr = addrOf(centerCount);
                end
            end else if (phase == 0) begin
                expReady = 1;
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("s_ready",      32'(s_ready),      32'(expReady));
        checkValue("write_en",     32'(write_en),     32'(expWe));
        checkValue("wr_addr",      32'(wr_addr),      32'(expWrAddr));
        checkValue("pixel_out",    32'(pixel_out),    32'(expPix));
        checkValue("center_addr",  32'(center_addr),  32'(expCAddr));
        checkValue("center_valid", 32'(center_valid), 32'(expCv));
        checkValue("frame_done",   32'(frame_done),   32'(expFd));
        checkValue("busy",         32'(busy),         32'(phase != 0));
    endtask

    task automatic applyStimulus(logic rst, logic abt, logic sv, logic [PW-1:0] pix, logic cd);
        reset = rst; abort = abt; s_valid = sv; s_pixel = pix; center_done = cd;
        @(posedge clk);
        modelEdge();
        #1;
        if (write_en === 1'b1) weSeen++;
        if (frame_done === 1'b1) fdSeen++;
        checkOutput();
    endtask

    task automatic loadFrame(int base);
        for (int k = 0; k < MN; k++) applyStimulus(0, 0, 1, PW'(base + k), 0);
    endtask

    initial begin
        reset = 1; abort = 0; s_valid = 0; s_pixel = '0; center_done = 0;
        phase = 0; loadCount = 0; centerCount = 0;
        expReady = 0; expWe = 0; expWrAddr = '0; expPix = '0; expCAddr = '0; expCv = 0; expFd = 0;
        weSeen = 0; fdSeen = 0;

        //          rst abt sv  pix    cd  rdy we  addr   pix    busy cv fd
        vecs[0] = '{1,  0,  0,  8'h00, 0,  0,  0,  6'h00, 8'h00, 0,   0, 0};
        vecs[1] = '{0,  0,  1,  8'hA5, 0,  1,  0,  6'h00, 8'h00, 0,   0, 0};
        vecs[2] = '{0,  0,  1,  8'h11, 0,  1,  1,  6'h00, 8'h11, 1,   0, 0};
        vecs[3] = '{0,  0,  0,  8'hEE, 1,  1,  0,  6'h00, 8'h11, 1,   0, 0};
        vecs[4] = '{0,  0,  1,  8'h22, 0,  1,  1,  6'h01, 8'h22, 1,   0, 0};
        vecs[5] = '{0,  0,  1,  8'h33, 0,  1,  1,  6'h02, 8'h33, 1,   0, 0};
        vecs[6] = '{0,  1,  1,  8'h44, 0,  0,  0,  6'h00, 8'h00, 0,   0, 0};
        vecs[7] = '{0,  0,  1,  8'h55, 0,  1,  0,  6'h00, 8'h00, 0,   0, 0};
        vecs[8] = '{0,  0,  1,  8'h66, 0,  1,  1,  6'h00, 8'h66, 1,   0, 0};
        vecs[9] = '{1,  0,  1,  8'h77, 0,  0,  0,  6'h00, 8'h00, 0,   0, 0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].abt, vecs[i].sv, vecs[i].pix, vecs[i].cd);
            checkValue("vec_ready", 32'(s_ready),      32'(vecs[i].eReady));
            checkValue("vec_we",    32'(write_en),     32'(vecs[i].eWe));
            checkValue("vec_addr",  32'(wr_addr),      32'(vecs[i].eAddr));
            checkValue("vec_pix",   32'(pixel_out),    32'(vecs[i].ePix));
            checkValue("vec_busy",  32'(busy),         32'(vecs[i].eBusy));
            checkValue("vec_cv",    32'(center_valid), 32'(vecs[i].eCv));
            checkValue("vec_fd",    32'(frame_done),   32'(vecs[i].eFd));
        end

        // Continuous load, then centers completed 5 cycles after each becomes valid.
        applyStimulus(0, 0, 0, 0, 0);
        weSeen = 0;
        loadFrame(0);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("load_we_count", 32'(weSeen), 32'(MN));
        checkValue("ready_after_load", 32'(s_ready), 32'(0));
        fdSeen = 0;
        for (int c = 0; c < MN; c++) begin
            for (int d = 0; d < 4; d++) applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("sweep_fd_count", 32'(fdSeen), 32'(1));

        // center_done held high, with the next frame streamed right behind it.
        loadFrame(8'h40);
        fdSeen = 0;
        for (int c = 0; c < MN + 1; c++) applyStimulus(0, 0, 1, PW'(8'h80 + c), 1);
        checkValue("held_fd_count", 32'(fdSeen), 32'(1));
        for (int k = 0; k < MN; k++) applyStimulus(0, 0, 1, PW'(8'hA0 + k), 0);
        for (int c = 0; c < MN + 2; c++) applyStimulus(0, 0, 0, 0, 1);

        // Abort after 20 pixels, then a full reload starting at address 0.
        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 1, PW'(k), 0);
        fdSeen = 0;
        applyStimulus(0, 1, 1, 8'hFF, 0);
        checkValue("abort_busy", 32'(busy), 32'(0));
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 8'h5A, 0);
        checkValue("reload_addr", 32'(wr_addr), 32'(0));
        for (int k = 1; k < MN; k++) applyStimulus(0, 0, 1, PW'(k), 0);
        checkValue("abort_no_fd", 32'(fdSeen), 32'(0));

        // Reset mid-sweep at center 0x13; later center_done must have no effect.
        begin
            int budget;
            budget = 0;
            while (center_addr !== 6'h13 && budget < 100) begin
                applyStimulus(0, 0, 0, 0, 1);
                budget++;
            end
            checkValue("reach_center_13", 32'(center_addr), 32'(6'h13));
        end
        applyStimulus(1, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 0, 1);
        checkValue("post_reset_cv", 32'(center_valid), 32'(0));

        // Randomized traffic including occasional abort and reset.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) < 7), PW'($urandom), ($urandom_range(0, 9) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eda_frame_sequencer.md
Name: eda_frame_sequencer

Overview:
- Front-end stage directly upstream of eda_regional_max.
- Accepts an M x N greyscale frame as a raster-order valid/ready pixel stream and writes it into the core's image memory (write_en/wr_addr/pixel_in).
- Once the frame is complete, sweeps center_addr over every pixel in raster order, advancing on the core's per-center completion strobe.
- Signals frame completion so the next frame can be loaded.

Parameters:
- M, 6, image rows
- N, 6, image columns
- PIXEL_WIDTH, 8, bits per pixel
- I_WIDTH, $clog2(M), row index width
- J_WIDTH, $clog2(N), column index width
- ADDR_WIDTH, I_WIDTH+J_WIDTH, address width; address = {row, col}

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  upstream pixel valid
- s_pixel  in  PIXEL_WIDTH  upstream pixel, raster order
- s_ready  out  1  sequencer can accept a pixel
- abort  in  1  synchronous frame abort
- write_en  out  1  core memory write strobe
- wr_addr  out  ADDR_WIDTH  core write address {row,col}
- pixel_out  out  PIXEL_WIDTH  core write data (to pixel_in)
- center_addr  out  ADDR_WIDTH  current window center {row,col}
- center_valid  out  1  center_addr is valid for the core
- center_done  in  1  core finished current center (core new_pixel)
- frame_done  out  1  one-cycle pulse after last center completes
- busy  out  1  high in LOAD or SWEEP

Behaviour:
- Reset: state=IDLE; row/col counters=0; write_en=0, wr_addr=0, pixel_out=0, center_addr=0, center_valid=0, frame_done=0, busy=0, s_ready=0 during the reset cycle.
- States: IDLE, LOAD, SWEEP.
- IDLE:
  - s_ready=1.
  - A handshake (s_valid&&s_ready) is accepted as pixel (0,0) and moves to LOAD.
- LOAD:
  - s_ready=1.
  - Each handshake increments col; col wraps N-1 -> 0 with row+1.
  - Address is formed by concatenation {row,col}, not row*N+col. Unused codes when M or N is not a power of 2 are never emitted.
- Write port timing:
  - Registered, 1-cycle latency: a handshake at edge k gives write_en=1, wr_addr={row,col}, pixel_out=s_pixel for exactly the cycle after k.
  - write_en=0 on cycles without a preceding handshake. Gaps in s_valid are allowed.
  - wr_addr and pixel_out hold their last values when write_en=0.
- LOAD -> SWEEP:
  - On the handshake of pixel (M-1,N-1); s_ready drops to 0 the next cycle.
  - No further pixels are accepted until the sweep ends.
- SWEEP entry:
  - First SWEEP cycle (the same cycle the last write_en is high): center_addr=0, center_valid=1.
  - The core therefore sees the final write no later than the first center.
- SWEEP advance:
  - When center_valid&&center_done, center_addr advances in raster order with the same wrap rules, effective next cycle.
  - center_done while center_valid=0 is ignored. center_done held high advances one center per cycle.
- SWEEP exit:
  - center_done on center (M-1,N-1): next cycle center_valid=0, frame_done=1 for one cycle, state=IDLE, counters=0, s_ready=1.
  - A new frame's first pixel may be accepted in that same frame_done cycle.
- busy: 1 in LOAD and SWEEP, 0 in IDLE.
- abort:
  - In any state: next cycle same as reset, except no frame_done is produced.
  - A pending write_en from a handshake at the abort edge is suppressed.
  - abort has priority over a simultaneous handshake or center_done.
- Reset or abort mid-LOAD discards the partial frame; the next accepted pixel is (0,0).
- Degenerate M=1 or N=1: counters still wrap correctly. M*N=1 goes IDLE -> SWEEP directly on the single handshake.

Test Plan:
- Continuous stream, M=N=6, pixels 0x00..0x23 -> write_en high for 36 consecutive cycles starting 1 cycle after the first handshake; wr_addr sequence 0x00..0x05, 0x08..0x0D, ..., 0x28..0x2D; pixel_out matches input; s_ready=0 after the 36th handshake.
- s_valid toggling every other cycle -> write_en toggles in lockstep one cycle delayed; addresses are contiguous with no skips or duplicates.
- After load, center_done pulsed 5 cycles after each center_valid -> center_addr steps 0x00,0x01,...,0x2D; frame_done is a single pulse one cycle after the 36th center_done; busy falls the same cycle.
- center_done held constantly high -> 36 centers in 36 cycles, then frame_done; a second frame streamed immediately is loaded from (0,0).
- abort asserted after 20 pixels -> next cycle IDLE, write_en=0, busy=0, no frame_done; reload of 36 pixels starts at wr_addr 0x00.
- reset asserted mid-SWEEP at center 0x13 -> next cycle all outputs at reset values; center_done afterwards is ignored.
